alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 134 +++++++++++++
 tb/tb_alu_pipe.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined 16-op ALU with valid/ready
// handshake, registered status flags and a consumed-result counter.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   y,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_sel;

  logic             s1_load;
  logic             s2_load;
  logic             fire;

  logic [WIDTH:0]   za;
  logic [WIDTH:0]   zb;
  logic [WIDTH:0]   sa;
  logic [WIDTH:0]   sb;
  logic [WIDTH:0]   y_d;
  logic             z_d;
  logic             n_d;
  logic             c_d;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;
  assign fire     = out_valid && out_ready;

  // zero-extended for arithmetic, sign-extended for logical ops
  assign za = {1'b0, s1_a};
  assign zb = {1'b0, s1_b};
  assign sa = {s1_a[WIDTH-1], s1_a};
  assign sb = {s1_b[WIDTH-1], s1_b};

  always_comb begin
    y_d = '0;
    if (s1_sel[3] == 1'b0) begin
      case (s1_sel[2:0])
        3'd0:    y_d = za + ONE;
        3'd1:    y_d = za - ONE;
        3'd2:    y_d = zb;
        3'd3:    y_d = zb + ONE;
        3'd4:    y_d = zb - ONE;
        3'd5:    y_d = za;
        3'd6:    y_d = za + zb;
        3'd7:    y_d = {s1_a, 1'b0};
        default: y_d = '0;
      endcase
    end else begin
      case (s1_sel[2:0])
        3'd0:    y_d = ~sa;
        3'd1:    y_d = ~sb;
        3'd2:    y_d = sa & sb;
        3'd3:    y_d = sa | sb;
        3'd4:    y_d = sa ^ sb;
        3'd5:    y_d = ~(sa ^ sb);
        3'd6:    y_d = ~(sa & sb);
        3'd7:    y_d = ~(sa | sb);
        default: y_d = '0;
      endcase
    end
  end

  assign z_d = (y_d[WIDTH-1:0] == '0);
  assign n_d = y_d[WIDTH-1];
  assign c_d = !s1_sel[3] && y_d[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_a     <= a;
        s1_b     <= b;
        s1_sel   <= sel;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        y         <= y_d;
        flag_z    <= z_d;
        flag_n    <= n_d;
        flag_c    <= c_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (fire) begin
      op_count <= op_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed plus randomized checks of alu_pipe
// against a queue-based arithmetic reference model.
module tb_alu_pipe;

  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [3:0]    sel = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W:0]    y;
  logic          flag_z;
  logic          flag_n;
  logic          flag_c;
  logic [CW-1:0] op_count;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // returns {c, n, z, y[W:0]} from the opcode rules in plain integers
  function automatic logic [7:0] ref_op(int ia, int ib, logic [3:0] op);
    int sa, sb, r;
    logic c, n, z;
    logic [W:0] yy;
    sa = (ia >= 2**(W-1)) ? ia - 2**W : ia;
    sb = (ib >= 2**(W-1)) ? ib - 2**W : ib;
    r = 0;
    if (!op[3]) begin
      case (op[2:0])
        3'd0: r = ia + 1;
        3'd1: r = ia - 1;
        3'd2: r = ib;
        3'd3: r = ib + 1;
        3'd4: r = ib - 1;
        3'd5: r = ia;
        3'd6: r = ia + ib;
        default: r = ia * 2;
      endcase
    end else begin
      case (op[2:0])
        3'd0: r = ~sa;
        3'd1: r = ~sb;
        3'd2: r = sa & sb;
        3'd3: r = sa | sb;
        3'd4: r = sa ^ sb;
        3'd5: r = ~(sa ^ sb);
        3'd6: r = ~(sa & sb);
        default: r = ~(sa | sb);
      endcase
    end
    r = r & (2**(W+1) - 1);
    z = (r % (2**W)) == 0;
    n = ((r >> (W-1)) & 1) == 1;
    c = !op[3] && (r >= 2**W);
    yy = r[W:0];
    return {c, n, z, yy};
  endfunction

  logic [7:0] q[$];
  int         consumed = 0;
  logic       hold_chk = 1'b0;
  logic [8:0] held = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      consumed = 0;
      hold_chk = 1'b0;
    end else begin
      if (hold_chk)
        check("hold", {out_valid, flag_c, flag_n, flag_z, y}, held);
      check("op_count", op_count, consumed % (2**CW));
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else if (out_ready) begin
          check("result", {flag_c, flag_n, flag_z, y}, q.pop_front());
          consumed++;
        end
      end
      hold_chk = out_valid && !out_ready;
      held = {out_valid, flag_c, flag_n, flag_z, y};
      if (in_valid && in_ready)
        q.push_back(ref_op(int'(a), int'(b), sel));
    end
  end

  task automatic drive_one(logic [3:0] da, logic [3:0] db, logic [3:0] ds);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    a = da;
    b = db;
    sel = ds;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) check("out_timeout", 0, 1);
  endtask

  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_flags", {flag_c, flag_n, flag_z}, 0);
    check("rst_op_count", op_count, 0);
    check("rst_in_ready", in_ready, 1);

    // latency and a+1 carry-out
    drive_one(4'hF, 4'h0, 4'b0000);
    check("lat_n1", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_n2", out_valid, 1);
    check("inc_y", y, 5'h10);
    check("inc_c", flag_c, 1);
    check("inc_z", flag_z, 1);
    @(posedge clk);
    #1;
    check("inc_cnt", op_count, 1);
    check("inc_drained", out_valid, 0);

    drive_one(4'h0, 4'h0, 4'b0001);
    wait_out();
    check("dec_y", y, 5'h1F);
    check("dec_c", flag_c, 1);
    check("dec_n", flag_n, 1);

    drive_one(4'h9, 4'h8, 4'b0110);
    wait_out();
    check("add_y", y, 5'h11);
    check("add_c", flag_c, 1);

    drive_one(4'hA, 4'h0, 4'b1000);
    wait_out();
    check("nota_y", y, 5'b00101);
    check("nota_c", flag_c, 0);

    drive_one(4'hC, 4'hA, 4'b1111);
    wait_out();
    check("nor_y", y, 5'b00001);
    check("nor_n", flag_n, 0);
    check("nor_c", flag_c, 0);
    @(posedge clk);
    #1;
    check("cnt_wrap", op_count, 1);

    // back-to-back, full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        in_valid = 1'b1;
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        sel = 4'($urandom_range(0, 15));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 10) check("b2b_in_ready", in_ready, 1);
      if (i >= 2) check("b2b_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("b2b_drained", q.size(), 0);

    // backpressure: two accepted, third stalls
    base = consumed;
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 4'h3; b = 4'h5; sel = 4'b0110;
    @(negedge clk);
    check("bp_acc0", in_ready, 1);
    @(posedge clk);
    #1;
    a = 4'h7; b = 4'h1; sel = 4'b1010;
    @(negedge clk);
    check("bp_acc1", in_ready, 1);
    @(posedge clk);
    #1;
    a = 4'hE; b = 4'h2; sel = 4'b0100;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall_ready", in_ready, 0);
      check("bp_stall_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_delivered", consumed - base, 3);
    check("bp_cnt", op_count, (base + 3) % (2**CW));

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      sel = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rand_drained", q.size(), 0);

    // asynchronous reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 4'h1; b = 4'h2; sel = 4'b0110;
    @(posedge clk);
    #1;
    a = 4'h4; sel = 4'b0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_y", y, 0);
    check("arst_flags", {flag_c, flag_n, flag_z}, 0);
    check("arst_cnt", op_count, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("no_stale", out_valid, 0);
    end
    check("post_rst_cnt", op_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
